// File: rtl/plab2_proc_fetch_unit_pkg.sv
// Shared definitions for the decoupled instruction-fetch front end:
// nop encoding, default reset vector, buffer entry layout and control states.
package plab2_proc_fetch_unit_pkg;

    // Instruction word presented to D whenever no valid instruction is buffered
    localparam logic [31:0] FETCH_NOP          = 32'h0;
    // Default first fetch address after reset
    localparam logic [31:0] FETCH_RESET_VECTOR = 32'h0000_1000;
    // Width of one buffered entry {inst, pc_plus4}
    localparam int          FETCH_ENTRY_W      = 64;

    // One buffered instruction together with its fall-through address
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc_plus4;
    } fetch_entry_t;

    // Control view of the fetch unit:
    //   RUN   - request issue allowed and accepted responses are kept
    //   STALL - credit exhausted or memory not ready, nothing issues this cycle
    //   FLUSH - stale responses still outstanding; they are discarded on arrival
    typedef enum logic [1:0] {
        FETCH_RUN   = 2'd0,
        FETCH_STALL = 2'd1,
        FETCH_FLUSH = 2'd2
    } ctrl_state_e;

    // Sequential fall-through address; wraps silently at 2^32
    function automatic logic [31:0] pc_incr(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/plab2_proc_fetch_fifo.sv
// Small circular queue with enqueue, dequeue and synchronous clear.
// Head entry is read combinationally so an entry written at cycle t is
// visible at the output in cycle t+1. Depth must be a power of two so the
// pointers wrap naturally.
module plab2_proc_fetch_fifo #(
    parameter int p_width       = 64,
    parameter int p_num_entries = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            clear,
    input  logic                            enq_val,
    input  logic [p_width-1:0]              enq_data,
    input  logic                            deq_val,
    output logic [p_width-1:0]              deq_data,
    output logic [$clog2(p_num_entries):0]  count
);

    localparam int          AW   = $clog2(p_num_entries);
    localparam logic [AW:0] FULL = (AW + 1)'(p_num_entries);

    logic [p_width-1:0] mem_reg [p_num_entries];
    logic [AW-1:0]      wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]      rd_ptr_reg, rd_ptr_next;
    logic [AW:0]        count_reg, count_next;
    logic               do_enq, do_deq;

    // Pointer and occupancy update; clear wins over any same-cycle enq/deq
    always_comb begin
        do_deq      = deq_val && (count_reg != '0);
        do_enq      = enq_val && ((count_reg != FULL) || do_deq) && !clear;
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (clear) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (do_enq) begin
                wr_ptr_next = wr_ptr_reg + AW'(1);
            end
            if (do_deq) begin
                rd_ptr_next = rd_ptr_reg + AW'(1);
            end
            case ({do_enq, do_deq})
                2'b10:   count_next = count_reg + (AW + 1)'(1);
                2'b01:   count_next = count_reg - (AW + 1)'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    // Pointer/occupancy state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Storage write; contents need no reset because occupancy gates their use
    always_ff @(posedge clk) begin
        if (do_enq) begin
            mem_reg[wr_ptr_reg] <= enq_data;
        end
    end

    assign deq_data = mem_reg[rd_ptr_reg];
    assign count    = count_reg;

endmodule

// File: rtl/plab2_proc_fetch_unit.sv
// Decoupled instruction fetch: owns the fetch PC, issues in-order imem
// requests under a credit scheme (in-flight + buffered <= p_num_entries),
// tags each request with its pc+4, buffers responses and presents the head
// to D. Redirects flush the buffer and mark outstanding responses as stale.
module plab2_proc_fetch_unit
    import plab2_proc_fetch_unit_pkg::*;
#(
    parameter int          p_num_entries  = 2,
    parameter logic [31:0] p_reset_vector = FETCH_RESET_VECTOR
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imemreq_val,
    input  logic        imemreq_rdy,
    output logic [31:0] imemreq_msg_addr,
    input  logic        imemresp_val,
    output logic        imemresp_rdy,
    input  logic [31:0] imemresp_msg_data,
    input  logic        redirect_val,
    input  logic [31:0] redirect_target,
    output logic        inst_val_D,
    input  logic        inst_rdy_D,
    output logic [31:0] inst_D,
    output logic [31:0] pc_plus4_D,
    input  logic        sd
);

    localparam int          CW      = $clog2(p_num_entries) + 1;
    localparam logic [CW:0] CREDITS = (CW + 1)'(p_num_entries);

    logic [31:0]              pc_f_reg, pc_f_next;
    logic [CW-1:0]            drop_cnt_reg, drop_cnt_next;
    logic [CW-1:0]            inflight;
    logic [CW-1:0]            occupancy;
    logic [CW:0]              used;
    logic                     credit_ok;
    logic                     req_fire;
    logic                     resp_fire;
    logic                     resp_keep;
    logic                     deq_fire;
    logic [31:0]              tag_head;
    logic [FETCH_ENTRY_W-1:0] buf_head;
    fetch_entry_t             head_entry;
    fetch_entry_t             resp_entry;
    ctrl_state_e              ctrl_state;
    logic                     sd_unused;

    // Every port already carries domain sd; the label needs no logic here
    assign sd_unused    = sd;
    // Space for every response was reserved when its request issued
    assign imemresp_rdy = 1'b1;

    // Control decode: credit, request/response/dequeue handshakes, next PC and drop count
    always_comb begin
        used      = {1'b0, inflight} + {1'b0, occupancy};
        credit_ok = (used < CREDITS);

        if (drop_cnt_reg != '0) begin
            ctrl_state = FETCH_FLUSH;
        end else if (!credit_ok || !imemreq_rdy) begin
            ctrl_state = FETCH_STALL;
        end else begin
            ctrl_state = FETCH_RUN;
        end

        // Redirect suppresses issue so the stale pc_F is never requested
        imemreq_val = reset && !redirect_val && credit_ok;
        req_fire    = imemreq_val && imemreq_rdy;
        // A response with nothing outstanding is a protocol error and is ignored
        resp_fire   = imemresp_val && (inflight != '0);
        resp_keep   = resp_fire && (ctrl_state != FETCH_FLUSH) && !redirect_val;
        deq_fire    = inst_val_D && inst_rdy_D && !redirect_val;

        pc_f_next = pc_f_reg;
        if (redirect_val) begin
            pc_f_next = redirect_target;
        end else if (req_fire) begin
            pc_f_next = pc_incr(pc_f_reg);
        end

        drop_cnt_next = drop_cnt_reg;
        if (redirect_val) begin
            // Everything still outstanding after this cycle's response is stale
            drop_cnt_next = inflight - CW'(resp_fire);
        end else if (resp_fire && (ctrl_state == FETCH_FLUSH)) begin
            drop_cnt_next = drop_cnt_reg - CW'(1);
        end
    end

    // Fetch PC and stale-response counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_f_reg     <= p_reset_vector;
            drop_cnt_reg <= '0;
        end else begin
            pc_f_reg     <= pc_f_next;
            drop_cnt_reg <= drop_cnt_next;
        end
    end

    // Tags of issued requests; its occupancy is the in-flight count
    plab2_proc_fetch_fifo #(
        .p_width       (32),
        .p_num_entries (p_num_entries)
    ) tag_fifo (
        .clk      (clk),
        .reset    (reset),
        .clear    (1'b0),
        .enq_val  (req_fire),
        .enq_data (pc_incr(pc_f_reg)),
        .deq_val  (resp_fire),
        .deq_data (tag_head),
        .count    (inflight)
    );

    assign resp_entry = '{inst: imemresp_msg_data, pc_plus4: tag_head};

    // Instruction buffer feeding D
    plab2_proc_fetch_fifo #(
        .p_width       (FETCH_ENTRY_W),
        .p_num_entries (p_num_entries)
    ) inst_buf (
        .clk      (clk),
        .reset    (reset),
        .clear    (redirect_val),
        .enq_val  (resp_keep),
        .enq_data (resp_entry),
        .deq_val  (deq_fire),
        .deq_data (buf_head),
        .count    (occupancy)
    );

    // Head presentation; data is zeroed when invalid so nothing stale leaks to D
    always_comb begin
        head_entry = buf_head;
        inst_val_D = (occupancy != '0);
        inst_D     = inst_val_D ? head_entry.inst     : FETCH_NOP;
        pc_plus4_D = inst_val_D ? head_entry.pc_plus4 : 32'h0;
    end

    assign imemreq_msg_addr = pc_f_reg;

    // Memory must never answer when nothing is outstanding
    always @(posedge clk) begin
        if (reset && imemresp_val) begin
            assert (inflight != '0);
        end
    end

endmodule

// File: tb/tb_plab2_proc_fetch_unit.sv
// Directed bench for the fetch unit: a 1-cycle in-order memory, a queue-based
// reference model checked every cycle, plus hand-computed literal checks.
module tb_plab2_proc_fetch_unit;

    localparam int N = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imemreq_val;
    logic        imemreq_rdy = 1'b0;
    logic [31:0] imemreq_msg_addr;
    logic        imemresp_val = 1'b0;
    logic        imemresp_rdy;
    logic [31:0] imemresp_msg_data = 32'h0;
    logic        redirect_val = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        inst_val_D;
    logic        inst_rdy_D = 1'b0;
    logic [31:0] inst_D;
    logic [31:0] pc_plus4_D;
    logic        sd = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct { logic [31:0] addr; bit stale; } infl_t;
    typedef struct { logic [31:0] inst; logic [31:0] pc4; } ent_t;

    logic [31:0] mem_q[$];
    infl_t       m_infl[$];
    ent_t        m_buf[$];
    logic [31:0] m_pc = 32'h1000;
    logic [31:0] deq_log[$];

    plab2_proc_fetch_unit #(.p_num_entries(N), .p_reset_vector(32'h1000)) dut (
        .clk               (clk),
        .reset             (reset),
        .imemreq_val       (imemreq_val),
        .imemreq_rdy       (imemreq_rdy),
        .imemreq_msg_addr  (imemreq_msg_addr),
        .imemresp_val      (imemresp_val),
        .imemresp_rdy      (imemresp_rdy),
        .imemresp_msg_data (imemresp_msg_data),
        .redirect_val      (redirect_val),
        .redirect_target   (redirect_target),
        .inst_val_D        (inst_val_D),
        .inst_rdy_D        (inst_rdy_D),
        .inst_D            (inst_D),
        .pc_plus4_D        (pc_plus4_D),
        .sd                (sd)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] addr);
        return addr ^ 32'hDEAD_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Memory: records accepted requests; answered in order by the driver
    always @(negedge clk) begin
        if (reset && imemreq_val && imemreq_rdy) mem_q.push_back(imemreq_msg_addr);
    end

    // Reference model and per-cycle comparison
    always @(negedge clk) begin
        if (!reset) begin
            check("rst_req_val", {31'b0, imemreq_val}, 32'h0);
            check("rst_inst_val", {31'b0, inst_val_D}, 32'h0);
            check("rst_inst", inst_D, 32'h0);
            check("rst_pc4", pc_plus4_D, 32'h0);
            m_pc = 32'h1000;
            m_infl.delete();
            m_buf.delete();
        end else begin
            bit          exp_req, exp_ival, fire, resp;
            logic [31:0] exp_inst, exp_pc4;
            infl_t       e;
            exp_req  = !redirect_val && ((m_infl.size() + m_buf.size()) < N);
            exp_ival = (m_buf.size() > 0);
            exp_inst = exp_ival ? m_buf[0].inst : 32'h0;
            exp_pc4  = exp_ival ? m_buf[0].pc4  : 32'h0;
            check("req_val", {31'b0, imemreq_val}, {31'b0, exp_req});
            if (exp_req) check("req_addr", imemreq_msg_addr, m_pc);
            check("inst_val", {31'b0, inst_val_D}, {31'b0, exp_ival});
            check("inst_D", inst_D, exp_inst);
            check("pc_plus4_D", pc_plus4_D, exp_pc4);
            fire = exp_req && imemreq_rdy;
            resp = imemresp_val && (m_infl.size() > 0);
            if (!redirect_val && exp_ival && inst_rdy_D) begin
                deq_log.push_back(m_buf[0].pc4);
                void'(m_buf.pop_front());
            end
            if (resp) begin
                e = m_infl.pop_front();
                if (!e.stale && !redirect_val) m_buf.push_back('{inst_of(e.addr), e.addr + 32'd4});
            end
            if (redirect_val) begin
                m_buf.delete();
                foreach (m_infl[i]) m_infl[i].stale = 1'b1;
                m_pc = redirect_target;
            end else if (fire) begin
                m_infl.push_back('{m_pc, 1'b0});
                m_pc = m_pc + 32'd4;
            end
        end
    end

    // One cycle of stimulus; returns at posedge+2 for literal checks
    task automatic cyc(input logic rq, input logic dr, input logic rd,
                       input logic [31:0] tgt, input logic mg);
        @(posedge clk);
        #1;
        imemreq_rdy     = rq;
        inst_rdy_D      = dr;
        redirect_val    = rd;
        redirect_target = tgt;
        if (mg && mem_q.size() > 0) begin
            imemresp_val      = 1'b1;
            imemresp_msg_data = inst_of(mem_q.pop_front());
        end else begin
            imemresp_val      = 1'b0;
            imemresp_msg_data = 32'h0;
        end
        #1;
    endtask

    task automatic drain();
        repeat (4) cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    endtask

    initial begin
        #1 reset = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

        // Test 1: reset release, sequential fetch from 0x1000
        deq_log.delete();
        cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        reset = 1'b1;
        #1;
        check("t1_first_val", {31'b0, imemreq_val}, 32'h1);
        check("t1_first_addr", imemreq_msg_addr, 32'h1000);
        cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        check("t1_inst0", inst_D, 32'hDEAD_1000);
        check("t1_pc4_0", pc_plus4_D, 32'h1004);
        repeat (6) cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        check("t1_log0", deq_log[0], 32'h1004);
        check("t1_log1", deq_log[1], 32'h1008);
        check("t1_log2", deq_log[2], 32'h100C);

        // Test 2: D stalls for 5 cycles, then resumes without loss or duplication
        deq_log.delete();
        repeat (5) cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        check("t2_req_blocked", {31'b0, imemreq_val}, 32'h0);
        check("t2_buf_full_val", {31'b0, inst_val_D}, 32'h1);
        repeat (8) cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        check("t2_log_size", {31'b0, deq_log.size() >= 4}, 32'h1);
        for (int i = 1; i < deq_log.size(); i++)
            check("t2_consecutive", deq_log[i], deq_log[i-1] + 32'd4);

        // Test 3: two requests in flight, redirect to 0x2000
        drain();
        repeat (3) cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        check("t3_two_inflight", {31'b0, imemreq_val}, 32'h0);
        deq_log.delete();
        cyc(1'b1, 1'b1, 1'b1, 32'h2000, 1'b0);
        check("t3_redir_noreq", {31'b0, imemreq_val}, 32'h0);
        cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        check("t3_addr_target", imemreq_msg_addr, 32'h2000);
        repeat (6) cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        check("t3_log0", deq_log[0], 32'h2004);
        check("t3_log1", deq_log[1], 32'h2008);

        // Test 4: redirect together with response and inst_rdy_D
        drain();
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        deq_log.delete();
        cyc(1'b1, 1'b1, 1'b1, 32'h3000, 1'b1);
        check("t4_redir_noreq", {31'b0, imemreq_val}, 32'h0);
        cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        check("t4_next_val", {31'b0, imemreq_val}, 32'h1);
        check("t4_next_addr", imemreq_msg_addr, 32'h3000);
        check("t4_buf_cleared", {31'b0, inst_val_D}, 32'h0);
        repeat (6) cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        check("t4_log0", deq_log[0], 32'h3004);
        check("t4_log_size", {31'b0, deq_log.size() >= 2}, 32'h1);

        // Test 5: memory not ready holds the address
        drain();
        cyc(1'b0, 1'b1, 1'b1, 32'h4000, 1'b1);
        repeat (3) begin
            cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
            check("t5_hold_addr", imemreq_msg_addr, 32'h4000);
            check("t5_hold_val", {31'b0, imemreq_val}, 32'h1);
        end
        cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        check("t5_advanced", imemreq_msg_addr, 32'h4004);

        // Test 6: asynchronous reset mid-stream
        drain();
        repeat (3) cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check("t6_pre_val", {31'b0, inst_val_D}, 32'h1);
        #1;
        reset = 1'b0;
        mem_q.delete();
        imemresp_val = 1'b0;
        #1;
        check("t6_async_ival", {31'b0, inst_val_D}, 32'h0);
        check("t6_async_inst", inst_D, 32'h0);
        check("t6_async_pc4", pc_plus4_D, 32'h0);
        check("t6_async_req", {31'b0, imemreq_val}, 32'h0);
        deq_log.delete();
        cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        reset = 1'b1;
        #1;
        check("t6_restart_val", {31'b0, imemreq_val}, 32'h1);
        check("t6_restart_addr", imemreq_msg_addr, 32'h1000);
        repeat (6) cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        check("t6_log0", deq_log[0], 32'h1004);

        repeat (2) cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
